// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmit path among N_REQ requesters.
// Grants a requester, strobes the serializer once, waits for tx_done or a timeout, then idles.
module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                     baud_out_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [8*N_REQ-1:0]       req_data_i,
    input  logic [4*N_REQ-1:0]       req_cfg_i,
    input  logic                     tx_active_i,
    input  logic                     tx_done_i,
    output logic [7:0]               data_in_o,
    output logic [1:0]               parity_type_o,
    output logic                     stop_bits_o,
    output logic                     data_length_o,
    output logic                     send_o,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] cur_id_o,
    output logic [N_REQ-1:0]         ack_o,
    output logic                     err_o,
    output logic                     busy_o
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(TIMEOUT);
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        GAP
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [7:0]       data_q, data_d;
    logic [3:0]       cfg_q, cfg_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             send_q, send_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             err_q, err_d;

    logic [2*N_REQ-1:0] req_rot;
    logic               found;
    logic [IDW-1:0]     winner;
    logic [7:0]         data_sel;
    logic [3:0]         cfg_sel;

    // tx_active is status only; sequencing relies solely on tx_done.
    logic unused_tx_active;
    assign unused_tx_active = tx_active_i;

    // Rotating the doubled request vector puts the pointer position at bit 0.
    always_comb begin
        req_rot = {req_i, req_i} >> ptr_q;
        found   = 1'b0;
        winner  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_rot[i]) begin
                found  = 1'b1;
                winner = IDW'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    assign data_sel = 8'(req_data_i >> (8 * int'(winner)));
    assign cfg_sel  = 4'(req_cfg_i >> (4 * int'(winner)));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        data_d  = data_q;
        cfg_d   = cfg_q;
        grant_d = grant_q;
        id_d    = id_q;
        send_d  = 1'b0;
        ack_d   = '0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    data_d  = data_sel;
                    cfg_d   = cfg_sel;
                    grant_d = ONE << winner;
                    id_d    = winner;
                    send_d  = 1'b1;
                    state_d = LOAD;
                    if (int'(winner) == N_REQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = winner + 1'b1;
                    end
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done_i || (cnt_q == CW'(TIMEOUT - 1))) begin
                    if (tx_done_i) begin
                        ack_d = ONE << id_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    grant_d = '0;
                    gap_d   = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge baud_out_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            cfg_q   <= '0;
            grant_q <= '0;
            id_q    <= '0;
            send_q  <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            cfg_q   <= cfg_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            send_q  <= send_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign data_in_o     = data_q;
    assign parity_type_o = cfg_q[3:2];
    assign stop_bits_o   = cfg_q[1];
    assign data_length_o = cfg_q[0];
    assign send_o        = send_q;
    assign grant_o       = grant_q;
    assign cur_id_o      = id_q;
    assign ack_o         = ack_q;
    assign err_o         = err_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter; expected grants come from a round-robin model.
// A second instance with GAP_CYCLES=0 covers back-to-back frame spacing.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, reqG0;
    logic [8*N-1:0] reqData;
    logic [4*N-1:0] reqCfg;
    logic           txActive, txDone, txDoneG0;

    logic [7:0]   dataIn, dataInG0;
    logic [1:0]   parityType, parityTypeG0;
    logic         stopBits, stopBitsG0, dataLength, dataLengthG0;
    logic         send, sendG0, err, errG0, busy, busyG0;
    logic [N-1:0] grant, grantG0, ack, ackG0;
    logic [1:0]   curId, curIdG0;

    logic [3:0] reqM;
    logic [7:0] dataM [N];
    logic [3:0] cfgM [N];
    int         ptrM;
    int         nChecks = 0;
    int         nFails  = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(1), .TIMEOUT(TIMEOUT)) u_dut (
        .baud_out_i(clk), .rst_i(rst), .req_i(req), .req_data_i(reqData), .req_cfg_i(reqCfg),
        .tx_active_i(txActive), .tx_done_i(txDone), .data_in_o(dataIn), .parity_type_o(parityType),
        .stop_bits_o(stopBits), .data_length_o(dataLength), .send_o(send), .grant_o(grant),
        .cur_id_o(curId), .ack_o(ack), .err_o(err), .busy_o(busy)
    );

    uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(0), .TIMEOUT(TIMEOUT)) u_dut_g0 (
        .baud_out_i(clk), .rst_i(rst), .req_i(reqG0), .req_data_i(reqData), .req_cfg_i(reqCfg),
        .tx_active_i(txActive), .tx_done_i(txDoneG0), .data_in_o(dataInG0), .parity_type_o(parityTypeG0),
        .stop_bits_o(stopBitsG0), .data_length_o(dataLengthG0), .send_o(sendG0), .grant_o(grantG0),
        .cur_id_o(curIdG0), .ack_o(ackG0), .err_o(errG0), .busy_o(busyG0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        req = reqM;
        for (int i = 0; i < N; i++) begin
            reqData[8*i +: 8] = dataM[i];
            reqCfg[4*i +: 4]  = cfgM[i];
        end
    endtask

    // Reference round-robin: first requester at or after the pointer, wrapping.
    function automatic int rrPick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
        ptrM = 0;
    endtask

    // Entered right after the edge that raised send; returns sampling the first IDLE cycle.
    task automatic serveFrame(input int latency, input bit timeoutIt, input bit keepReq, input bit spurious);
        int         id;
        logic [7:0] grantedData;
        logic [3:0] grantedCfg;
        bit         noisy;
        id          = rrPick(reqM, ptrM);
        ptrM        = (id + 1) % N;
        grantedData = dataM[id];
        grantedCfg  = cfgM[id];
        checkOutput("send_on_grant", 32'(send), 1);
        checkOutput("grant_onehot", 32'(grant), 1 << id);
        checkOutput("cur_id", 32'(curId), id);
        checkOutput("data_in", 32'(dataIn), 32'(grantedData));
        checkOutput("cfg", 32'({parityType, stopBits, dataLength}), 32'(grantedCfg));
        checkOutput("busy_load", 32'(busy), 1);
        if (spurious) txDone = 1'b1;
        tick();
        txDone = 1'b0;
        checkOutput("send_single", 32'(send), 0);
        checkOutput("no_ack_load", 32'(ack), 0);
        noisy = 1'b0;
        if (!timeoutIt) begin
            repeat (latency) begin
                tick();
                if (ack !== '0 || err !== 1'b0 || send !== 1'b0) noisy = 1'b1;
            end
            txDone = 1'b1;
            tick();
            txDone = 1'b0;
            checkOutput("wait_quiet", 32'(noisy), 0);
            checkOutput("ack_owner", 32'(ack), 1 << id);
            checkOutput("err_none", 32'(err), 0);
            if (!keepReq) begin
                reqM[id] = 1'b0;
            end else begin
                dataM[id] = 8'($urandom);
                cfgM[id]  = 4'($urandom);
            end
            applyStimulus();
        end else begin
            repeat (TIMEOUT - 1) begin
                tick();
                if (ack !== '0 || err !== 1'b0 || send !== 1'b0) noisy = 1'b1;
            end
            tick();
            checkOutput("wait_quiet", 32'(noisy), 0);
            checkOutput("err_timeout", 32'(err), 1);
            checkOutput("ack_none", 32'(ack), 0);
        end
        checkOutput("grant_gap", 32'(grant), 0);
        checkOutput("busy_gap", 32'(busy), 1);
        tick();
        checkOutput("pulse_single", 32'({ack, err}), 0);
        checkOutput("busy_idle", 32'(busy), 0);
        checkOutput("data_hold", 32'(dataIn), 32'(grantedData));
    endtask

    initial begin
        rst = 1'b1; txActive = 1'b0; txDone = 1'b0; txDoneG0 = 1'b0;
        reqG0 = '0; reqM = '0; ptrM = 0;
        for (int i = 0; i < N; i++) begin
            dataM[i] = '0;
            cfgM[i]  = '0;
        end
        applyStimulus();
        tick();
        tick();
        checkOutput("rst_send", 32'(send), 0);
        checkOutput("rst_grant", 32'(grant), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_ackerr", 32'({ack, err}), 0);
        checkOutput("rst_data", 32'(dataIn), 0);
        checkOutput("rst_cfg", 32'({parityType, stopBits, dataLength}), 0);
        checkOutput("rst_curid", 32'(curId), 0);
        checkOutput("rst_busy_g0", 32'(busyG0), 0);
        rst = 1'b0;

        $display("[TB] single requester");
        reqM = 4'b0001; dataM[0] = 8'hA5; cfgM[0] = 4'b0000;
        applyStimulus();
        tick();
        serveFrame(4, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("no_regrant_send", 32'(send), 0);
        checkOutput("no_regrant_busy", 32'(busy), 0);

        $display("[TB] alternating 1010");
        reqM = 4'b1010;
        for (int i = 0; i < N; i++) begin
            dataM[i] = 8'($urandom);
            cfgM[i]  = 4'($urandom);
        end
        applyStimulus();
        doReset();
        for (int f = 0; f < 4; f++) begin
            tick();
            serveFrame($urandom_range(0, 14), 1'b0, 1'b1, 1'b0);
        end
        reqM = '0;
        applyStimulus();

        $display("[TB] all requesting");
        reqM = 4'b1111;
        applyStimulus();
        doReset();
        for (int f = 0; f < 8; f++) begin
            tick();
            serveFrame($urandom_range(0, 14), 1'b0, 1'b1, 1'b0);
        end
        reqM = '0;
        applyStimulus();
        tick();
        checkOutput("idle_after_all", 32'(busy), 0);

        $display("[TB] timeout and coincident done");
        reqM = 4'b0101; dataM[0] = 8'($urandom); dataM[2] = 8'($urandom);
        applyStimulus();
        tick();
        serveFrame(0, 1'b1, 1'b0, 1'b0);
        tick();
        serveFrame(TIMEOUT - 1, 1'b0, 1'b0, 1'b0);
        tick();
        serveFrame($urandom_range(0, 14), 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during wait");
        reqM = 4'b0010; dataM[1] = 8'h3C; cfgM[1] = 4'b1011;
        applyStimulus();
        tick();
        checkOutput("t5_send", 32'(send), 1);
        checkOutput("t5_grant", 32'(grant), 4'b0010);
        tick();
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        checkOutput("async_send", 32'(send), 0);
        checkOutput("async_grant", 32'(grant), 0);
        checkOutput("async_busy", 32'(busy), 0);
        checkOutput("async_data", 32'(dataIn), 0);
        checkOutput("async_cfg", 32'({parityType, stopBits, dataLength}), 0);
        checkOutput("async_curid", 32'(curId), 0);
        reqM = 4'b1001;
        applyStimulus();
        ptrM = 0;
        tick();
        rst = 1'b0;
        checkOutput("post_rst_ackerr", 32'({ack, err}), 0);
        tick();
        serveFrame($urandom_range(0, 14), 1'b0, 1'b0, 1'b0);
        tick();
        serveFrame($urandom_range(0, 14), 1'b0, 1'b0, 1'b0);

        $display("[TB] zero gap back-to-back");
        reqM = '0; dataM[0] = 8'h5A; dataM[1] = 8'hC3;
        applyStimulus();
        reqG0 = 4'b0011;
        tick();
        checkOutput("g0_send0", 32'(sendG0), 1);
        checkOutput("g0_grant0", 32'(grantG0), 4'b0001);
        checkOutput("g0_data0", 32'(dataInG0), 32'h5A);
        tick();
        repeat (3) tick();
        txDoneG0 = 1'b1;
        tick();
        txDoneG0 = 1'b0;
        checkOutput("g0_ack0", 32'(ackG0), 4'b0001);
        checkOutput("g0_grant_drop", 32'(grantG0), 0);
        checkOutput("g0_send_ackcyc", 32'(sendG0), 0);
        checkOutput("g0_busy_ackcyc", 32'(busyG0), 0);
        reqG0 = 4'b0010;
        tick();
        checkOutput("g0_send1", 32'(sendG0), 1);
        checkOutput("g0_grant1", 32'(grantG0), 4'b0010);
        checkOutput("g0_data1", 32'(dataInG0), 32'hC3);
        tick();
        txDoneG0 = 1'b1;
        tick();
        txDoneG0 = 1'b0;
        checkOutput("g0_ack1", 32'(ackG0), 4'b0010);
        checkOutput("g0_err1", 32'(errG0), 0);
        reqG0 = '0;
        tick();
        checkOutput("g0_idle", 32'({sendG0, ackG0, busyG0}), 0);

        $display("[TB] random traffic");
        for (int f = 0; f < 8; f++) begin
            logic [3:0] newReq;
            newReq = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                if (newReq[i] && !reqM[i]) begin
                    dataM[i] = 8'($urandom);
                    cfgM[i]  = 4'($urandom);
                end
            end
            reqM = reqM | newReq;
            applyStimulus();
            tick();
            serveFrame($urandom_range(0, 14), 1'b0, 1'b0, 1'b0);
        end
        reqM = '0;
        applyStimulus();
        tick();
        checkOutput("final_idle", 32'({send, busy, grant}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
